// File: rtl/seq_cmp.sv
// -----------------------------------------------------------------------------
// seq_cmp -- round-level sequence comparator for the Simon Says datapath.
//
// Checks one player round: up to MAX_LEN entries, one per sw_valid pulse, are
// compared against the expected pattern, which is read from the pattern store
// through exp_addr/exp_data.  The round ends in pass or fail with the failing
// step index, and optionally a per-step timeout.
//
// Optional feature macro: SEQ_CMP_TIMEOUT_EN
//   defined   : a per-step timer fails the round after TIMEOUT idle cycles
//   undefined : no timer is built, timeout is tied to 0, WAIT holds forever
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   start          1-cycle pulse, begins a round (ignored unless idle)
//   seq_len        steps in the round, latched on accepted start
//   sw, sw_valid   player entry and its 1-cycle qualifier
//   exp_addr       index of the expected entry (= current step)
//   exp_data       expected entry at exp_addr (combinational, same cycle)
//   busy           round in progress
//   done           1-cycle pulse when a round finishes
//   pass, fail     round result, held until the next accepted start
//   timeout        fail was caused by the step timer, held with fail
//   err_step       step index of the failure, held with fail
//   dbg_state      current FSM state (0 IDLE, 1 WAIT, 2 DONE)
//
// Handshake: start and sw_valid are fire-and-forget pulses with no ready.
// start is consumed only in IDLE; sw_valid is consumed only in WAIT (busy=1).
// Any pulse arriving in another state is dropped, including a sw_valid that
// coincides with an accepted start.
// -----------------------------------------------------------------------------
module seq_cmp #(
  parameter int WIDTH   = 4,
  parameter int MAX_LEN = 32,
  parameter int TIMEOUT = 50_000_000,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LW-1:0]    seq_len,
  input  logic [WIDTH-1:0] sw,
  input  logic             sw_valid,
  output logic [LW-1:0]    exp_addr,
  input  logic [WIDTH-1:0] exp_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [LW-1:0]    err_step,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [LW-1:0] MAX_LEN_LW = LW'(MAX_LEN);

  state_t        state;
  logic [LW-1:0] step;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_clamped;
  logic          match;
  logic          last_step;
  logic          tmo_hit;

  assign len_clamped = (seq_len > MAX_LEN_LW) ? MAX_LEN_LW : seq_len;
  assign match       = (sw == exp_data);
  // len_q is never 0 while in WAIT, so len_q-1 cannot underflow there.
  assign last_step   = (step == (len_q - LW'(1)));
  assign exp_addr    = step;
  assign dbg_state   = state;

`ifdef SEQ_CMP_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] timer;
  logic          timeout_q;

  // Expiry is only acted on in WAIT and only when no entry arrives that
  // cycle, so an entry on the expiry cycle wins.
  assign tmo_hit = (timer == TW'(TIMEOUT - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      timer     <= '0;
      timeout_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      timer     <= '0;
      timeout_q <= 1'b0;
    end else if (state == S_WAIT) begin
      if (sw_valid) begin
        timer <= '0;
      end else if (tmo_hit) begin
        timeout_q <= 1'b1;
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      err_step <= '0;
      step     <= '0;
      len_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q    <= len_clamped;
            pass     <= 1'b0;
            fail     <= 1'b0;
            err_step <= '0;
            step     <= '0;
            if (len_clamped == '0) begin
              // Empty round trivially matches.
              pass  <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (sw_valid) begin
            if (match) begin
              if (last_step) begin
                pass  <= 1'b1;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                step <= step + LW'(1);
              end
            end else begin
              fail     <= 1'b1;
              err_step <= step;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end
          end else if (tmo_hit) begin
            fail     <= 1'b1;
            err_step <= step;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_cmp.sv
// -----------------------------------------------------------------------------
// tb_seq_cmp -- directed and randomised round checks for seq_cmp.
// Result words {pass, fail, timeout, err_step} are queued when the decisive
// stimulus is driven and compared whenever done pulses.
// -----------------------------------------------------------------------------
module tb_seq_cmp;

  localparam int WIDTH   = 4;
  localparam int MAX_LEN = 32;
  localparam int TIMEOUT = 10;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int RW      = 3 + LW;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [LW-1:0]    seq_len = '0;
  logic [WIDTH-1:0] sw = '0;
  logic             sw_valid = 1'b0;
  logic [LW-1:0]    exp_addr;
  logic [WIDTH-1:0] exp_data;
  logic             busy, done, pass, fail, timeout;
  logic [LW-1:0]    err_step;
  logic [1:0]       dbg_state;

  // pattern store model
  logic [WIDTH-1:0] pat [0:63];
  assign exp_data = pat[exp_addr];

  seq_cmp #(
    .WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .LW(LW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .seq_len(seq_len),
    .sw(sw), .sw_valid(sw_valid), .exp_addr(exp_addr), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .err_step(err_step), .dbg_state(dbg_state)
  );

  // scoreboard
  logic [RW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  function automatic logic [RW-1:0] mk(input logic p, input logic f,
                                        input logic t, input int e);
    return {p, f, t, LW'(e)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock; outputs sampled 1 time unit after the edge
  task automatic tick();
    logic [RW-1:0] got;
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      done_cnt++;
      got = {pass, fail, timeout, err_step};
      chk("pass_fail_excl", {31'd0, pass & fail}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL done_unexpected got=%0h exp=none", got);
      end else begin
        chk("result", {{(32-RW){1'b0}}, got}, {{(32-RW){1'b0}}, exp_q.pop_front()});
      end
    end
  endtask

  // driver tasks
  task automatic do_start(input int len);
    start   = 1'b1;
    seq_len = LW'(len);
    tick();
    start   = 1'b0;
  endtask

  task automatic enter(input logic [WIDTH-1:0] v);
    sw       = v;
    sw_valid = 1'b1;
    tick();
    sw_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_busy"}, {31'd0, busy}, 0);
    chk({pfx, "_done"}, {31'd0, done}, 0);
    chk({pfx, "_pass"}, {31'd0, pass}, 0);
    chk({pfx, "_fail"}, {31'd0, fail}, 0);
    chk({pfx, "_timeout"}, {31'd0, timeout}, 0);
    chk({pfx, "_err_step"}, {26'd0, err_step}, 0);
    chk({pfx, "_exp_addr"}, {26'd0, exp_addr}, 0);
    chk({pfx, "_state"}, {30'd0, dbg_state}, 0);
  endtask

  int len, k, n;
  logic [WIDTH-1:0] bad_val;

  initial begin
    for (int i = 0; i < 64; i++) pat[i] = '0;

    // reset
    reset = 1'b1;
    tick();
    tick();
    chk_all_zero("rst0");
    reset = 1'b0;
    tick();

    // sw_valid in IDLE is ignored
    enter(4'd5);
    chk("idle_sw_addr", {26'd0, exp_addr}, 0);
    chk("idle_sw_busy", {31'd0, busy}, 0);

    // round 1,2,4 -> pass; start+sw_valid together drops the entry
    pat[0] = 4'd1; pat[1] = 4'd2; pat[2] = 4'd4;
    sw = 4'd1;
    sw_valid = 1'b1;
    do_start(3);
    sw_valid = 1'b0;
    chk("p1_busy", {31'd0, busy}, 1);
    chk("p1_addr0", {26'd0, exp_addr}, 0);
    enter(4'd1);
    chk("p1_addr1", {26'd0, exp_addr}, 1);
    tick();
    enter(4'd2);
    chk("p1_addr2", {26'd0, exp_addr}, 2);
    exp_q.push_back(mk(1, 0, 0, 0));
    enter(4'd4);
    chk("p1_done", {31'd0, done}, 1);
    chk("p1_busy_end", {31'd0, busy}, 0);
    tick();
    chk("p1_done_1cyc", {31'd0, done}, 0);
    chk("p1_pass_hold", {31'd0, pass}, 1);

    // round 1,2,4,8 with entries 1,2,8 -> fail at step 2
    pat[3] = 4'd8;
    do_start(4);
    chk("f1_pass_clr", {31'd0, pass}, 0);
    enter(4'd1);
    enter(4'd2);
    exp_q.push_back(mk(0, 1, 0, 2));
    enter(4'd8);
    chk("f1_done", {31'd0, done}, 1);
    chk("f1_err_step", {26'd0, err_step}, 2);
    enter(4'd8);  // lands in the DONE cycle, ignored
    tick();
    chk("f1_fail_hold", {31'd0, fail}, 1);
    chk("f1_err_hold", {26'd0, err_step}, 2);
    chk("f1_busy", {31'd0, busy}, 0);

    // empty round, second start in DONE ignored
    exp_q.push_back(mk(1, 0, 0, 0));
    do_start(0);
    chk("z_done", {31'd0, done}, 1);
    chk("z_busy", {31'd0, busy}, 0);
    do_start(3);
    chk("z_start_ign_busy", {31'd0, busy}, 0);
    chk("z_start_ign_pass", {31'd0, pass}, 1);
    tick();
    chk("z_idle_busy", {31'd0, busy}, 0);

    // randomised rounds, failing at step k or passing when k == len
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 6);
      k = $urandom_range(0, len);
      for (int i = 0; i < len; i++) pat[i] = WIDTH'($urandom_range(0, 15));
      do_start(len);
      chk("rnd_busy", {31'd0, busy}, 1);
      for (int i = 0; i < len && i <= k; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        chk("rnd_addr", {26'd0, exp_addr}, i);
        if (i == k) begin
          bad_val = pat[i] ^ WIDTH'($urandom_range(1, 15));
          exp_q.push_back(mk(0, 1, 0, i));
          enter(bad_val);
        end else begin
          if (i == len - 1) exp_q.push_back(mk(1, 0, 0, 0));
          enter(pat[i]);
        end
      end
      chk("rnd_done", {31'd0, done}, 1);
      tick();
    end

    // seq_len 40 clamps to 32; mid-round start ignored
    for (int i = 0; i < MAX_LEN; i++) pat[i] = WIDTH'($urandom_range(0, 15));
    pat[MAX_LEN] = pat[0] + 4'd1;
    do_start(40);
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i == 10) begin
        do_start(2);
        chk("cl_start_ign_addr", {26'd0, exp_addr}, 10);
        chk("cl_start_ign_busy", {31'd0, busy}, 1);
      end
      chk("cl_addr", {26'd0, exp_addr}, i);
      if (i == MAX_LEN - 1) exp_q.push_back(mk(1, 0, 0, 0));
      enter(pat[i]);
    end
    chk("cl_done", {31'd0, done}, 1);
    chk("cl_pass", {31'd0, pass}, 1);
    tick();

    // later start clears pass; reset at step 2 aborts the round
    do_start(5);
    chk("st_pass_clr", {31'd0, pass}, 0);
    enter(pat[0]);
    enter(pat[1]);
    chk("mr_addr2", {26'd0, exp_addr}, 2);
    reset = 1'b1;
    tick();
    chk_all_zero("rst1");
    reset = 1'b0;
    tick();

`ifdef SEQ_CMP_TIMEOUT_EN
    // one correct entry then idle -> timeout at step 1
    pat[0] = 4'd3; pat[1] = 4'd5;
    do_start(2);
    enter(4'd3);
    exp_q.push_back(mk(0, 1, 1, 1));
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, TIMEOUT);
    chk("tmo_flag", {31'd0, timeout}, 1);
    tick();
    // entry on the expiry cycle wins
    do_start(2);
    enter(4'd3);
    repeat (TIMEOUT - 1) tick();
    chk("tmo_not_yet", {31'd0, fail}, 0);
    exp_q.push_back(mk(1, 0, 0, 0));
    enter(4'd5);
    chk("tmo_race_done", {31'd0, done}, 1);
    chk("tmo_race_flag", {31'd0, timeout}, 0);
    tick();
`else
    // no timer: WAIT holds indefinitely
    pat[0] = 4'd3; pat[1] = 4'd5;
    do_start(2);
    enter(4'd3);
    repeat (60) tick();
    chk("hold_busy", {31'd0, busy}, 1);
    chk("hold_timeout", {31'd0, timeout}, 0);
    chk("hold_addr", {26'd0, exp_addr}, 1);
    exp_q.push_back(mk(1, 0, 0, 0));
    enter(4'd5);
    chk("hold_done", {31'd0, done}, 1);
    tick();
`endif

    chk("queue_empty", exp_q.size(), 0);
    chk("done_count_nonzero", {31'd0, done_cnt > 0}, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global bound so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
